// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame serializer: start, LSB-first data, optional parity, stop
// One i_clk cycle per bit; all line-facing outputs are computed from next state and registered.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_n;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  load;
  logic                  tx_n;
  logic                  busy_n;
  logic                  done_n;
  logic [DATA_WIDTH-1:0] shifted;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      data_q       <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      o_tx         <= 1'b1;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      o_tx         <= tx_n;
      o_busy       <= busy_n;
      o_frame_done <= done_n;
      if (load) begin
        data_q    <= i_data;
        par_en_q  <= i_par_en;
        par_typ_q <= i_par_typ;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (i_data_valid) begin
          load    = 1'b1;
          state_n = START;
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = DATA;
      end
      DATA: begin
        if (cnt == LAST_BIT) begin
          cnt_n   = '0;
          state_n = par_en_q ? PARITY : STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: state_n = STOP;
      STOP:   state_n = IDLE;
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Outputs reflect the state being entered so they come straight off flops.
    shifted = data_q >> cnt_n;
    tx_n    = 1'b1;
    busy_n  = 1'b1;
    done_n  = 1'b0;
    case (state_n)
      IDLE:    busy_n = 1'b0;
      START:   tx_n   = 1'b0;
      DATA:    tx_n   = shifted[0];
      PARITY:  tx_n   = (^data_q) ^ par_typ_q;
      STOP:    done_n = 1'b1;
      default: busy_n = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame against a frame-list model
// Expected frames are built as bit lists from the framing rules and compared cycle by cycle.
module tb_uart_tx_frame;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic          valid;
  logic          pe;
  logic          pt;
  logic          tx;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (data),
    .i_data_valid(valid),
    .i_par_en    (pe),
    .i_par_typ   (pt),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_frame_done(done)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Frame as it should appear on the line: start, data LSB first, parity, stop.
  function automatic void build(input logic [DW-1:0] d, input bit p_en, input bit p_odd);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (p_en) exp_q.push_back(p_odd ? (ones % 2 == 0) : (ones % 2 == 1));
    exp_q.push_back(1'b1);
  endfunction

  task automatic start(input logic [DW-1:0] d, input bit p_en, input bit p_odd);
    data  = d;
    pe    = p_en;
    pt    = p_odd;
    valid = 1'b1;
    build(d, p_en, p_odd);
  endtask

  // noise: random valid pulses mid-frame; hold: keep valid high and present next_d at the end.
  task automatic check_frame(input string tag, input bit noise, input bit hold,
                             input logic [DW-1:0] next_d);
    int n;
    n = exp_q.size();
    check({tag, "_len"}, 1'(n == 2 + DW + int'(pe)), 1'b1);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      check($sformatf("%s_tx%0d", tag, j), tx, exp_q[j]);
      check($sformatf("%s_busy%0d", tag, j), busy, 1'b1);
      check($sformatf("%s_done%0d", tag, j), done, 1'(j == n - 1));
      data = DW'($urandom);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      if (hold) begin
        valid = 1'b1;
        if (j == n - 1) begin
          data = next_d;
          pe   = 1'b0;
          pt   = 1'b0;
        end
      end else if (noise) begin
        valid = 1'($urandom);
      end else begin
        valid = 1'b0;
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    valid = 1'b0;
    check({tag, "_idle_tx"}, tx, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_done"}, done, 1'b0);
  endtask

  initial begin
    bit           r_pe;
    bit           r_pt;
    bit           r_noise;
    logic [DW-1:0] r_d;

    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    pe    = 1'b0;
    pt    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Valid presented together with reset release: first edge after reset accepts.
    rst = 1'b0;
    start(8'hA5, 1'b0, 1'b0);
    check_frame("a5", 1'b0, 1'b0, '0);
    idle_check("a5");
    idle_check("a5b");

    start(8'h03, 1'b1, 1'b0);
    check_frame("p03e", 1'b0, 1'b0, '0);
    idle_check("p03e");
    start(8'h03, 1'b1, 1'b1);
    check_frame("p03o", 1'b0, 1'b0, '0);
    idle_check("p03o");
    start(8'h00, 1'b1, 1'b1);
    check_frame("p00o", 1'b0, 1'b0, '0);
    idle_check("p00o");
    start(8'hFF, 1'b1, 1'b0);
    check_frame("pffe", 1'b0, 1'b0, '0);
    idle_check("pffe");

    // Back-to-back with valid held: exactly one idle cycle between frames.
    start(8'h55, 1'b0, 1'b0);
    check_frame("b2b1", 1'b0, 1'b1, 8'h0F);
    @(negedge clk);
    check("b2b_gap_tx", tx, 1'b1);
    check("b2b_gap_busy", busy, 1'b0);
    start(8'h0F, 1'b0, 1'b0);
    check_frame("b2b2", 1'b0, 1'b0, '0);
    idle_check("b2b2");

    // Valid pulses while busy must not queue a second frame.
    start(8'hA5, 1'b0, 1'b0);
    check_frame("noise", 1'b1, 1'b0, '0);
    idle_check("noise1");
    idle_check("noise2");
    idle_check("noise3");

    // Reset while data bit 3 is on the line.
    start(8'hA5, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("rstmid_tx%0d", j), tx, exp_q[j]);
      valid = 1'b0;
      data  = DW'($urandom);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_tx", tx, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_done", done, 1'b0);
    rst = 1'b0;
    start(8'hA5, 1'b0, 1'b0);
    check_frame("after_rst", 1'b0, 1'b0, '0);
    idle_check("after_rst");

    for (int f = 0; f < 30; f++) begin
      r_d     = DW'($urandom);
      r_pe    = 1'($urandom);
      r_pt    = 1'($urandom);
      r_noise = 1'($urandom);
      start(r_d, r_pe, r_pt);
      check_frame($sformatf("rnd%0d", f), r_noise, 1'b0, '0);
      idle_check($sformatf("rnd%0d", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, payload bits per frame, legal range 5..9.
REQ-002 i_clk  input  1  bit-rate clock, driven by the divided clock output of the upstream clock divider; one bit period equals one i_clk cycle.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_data  input  DATA_WIDTH  parallel payload to transmit.
REQ-005 i_data_valid  input  1  payload request; accepted only when the module is idle.
REQ-006 i_par_en  input  1  1 = insert parity bit, 0 = no parity bit.
REQ-007 i_par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-008 o_tx  output  1  serial line, registered, idle high.
REQ-009 o_busy  output  1  registered, high while a frame is in flight.
REQ-010 o_frame_done  output  1  registered, one-cycle pulse during the stop bit.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY and STOP, all registered.
REQ-012 In IDLE, o_tx SHALL be 1 and o_busy SHALL be 0.
REQ-013 Acceptance occurs on a rising i_clk edge where state = IDLE and i_data_valid = 1.
REQ-014 On acceptance, i_data, i_par_en and i_par_typ SHALL be captured into internal registers, and the FSM SHALL move to START.
REQ-015 Inputs SHALL NOT be sampled again until the FSM returns to IDLE; changes to them mid-frame SHALL NOT alter the frame.
REQ-016 Latency: if acceptance is at edge k, then after edge k o_tx = 0 (start bit) and o_busy = 1.
REQ-017 DATA state SHALL last exactly DATA_WIDTH cycles and drive captured bits LSB first: bit i appears after edge k+1+i.
REQ-018 A bit counter of width ceil(log2(DATA_WIDTH)) SHALL count 0..DATA_WIDTH-1 in DATA and return to 0 on leaving DATA.
REQ-019 If captured par_en = 1, PARITY SHALL follow DATA for one cycle; o_tx SHALL be the XOR of the captured data for even parity and its inverse for odd parity.
REQ-020 If captured par_en = 0, DATA SHALL go directly to STOP.
REQ-021 STOP SHALL last one cycle with o_tx = 1, o_busy = 1 and o_frame_done = 1.
REQ-022 STOP SHALL go to IDLE unconditionally; o_busy SHALL fall on the following edge.
REQ-023 Frame length in busy cycles SHALL be 2 + DATA_WIDTH + par_en.
REQ-024 Every frame SHALL be followed by at least one IDLE cycle.
REQ-025 i_data_valid held high continuously SHALL start the next frame at the first IDLE edge, giving exactly one idle cycle (o_tx = 1) between frames.
REQ-026 i_data_valid asserted while o_busy = 1 SHALL be ignored and SHALL NOT be queued.
REQ-027 o_frame_done SHALL be 0 in every state other than STOP.
REQ-028 No glitch path SHALL exist: o_tx, o_busy and o_frame_done SHALL come directly from flops.
REQ-029 Any unused or illegal state encoding SHALL go to IDLE on the next edge.

Reset
REQ-030 While i_rst = 1 at a rising edge, the FSM SHALL go to IDLE with o_tx = 1, o_busy = 0, o_frame_done = 0, bit counter = 0, and captured registers = 0.
REQ-031 Reset SHALL take priority over acceptance and over every state transition, including mid-frame; the partial frame is abandoned and the line returns high on that edge.
REQ-032 The first acceptance after reset is possible on the first edge where i_rst = 0.

Verification
REQ-033 i_data = 0xA5, i_par_en = 0, one-cycle valid -> o_tx = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); o_busy high for 10 cycles; o_frame_done high only on cycle 10.
REQ-034 i_data = 0x03, i_par_en = 1, i_par_typ = 0 -> parity bit 0, 11-cycle frame; repeat with i_par_typ = 1 -> parity bit 1.
REQ-035 i_data = 0x00 with odd parity -> parity bit 1; i_data = 0xFF with even parity -> parity bit 0.
REQ-036 i_data_valid held high with data 0x55 then 0x0F, no parity -> two frames separated by exactly one o_tx = 1 idle cycle; i_data changes during frame 1 do not affect frame 1.
REQ-037 i_rst pulsed during data bit 3 of 0xA5 -> on that edge o_tx = 1, o_busy = 0; valid on the next edge starts a fresh complete frame.
REQ-038 i_data_valid pulsed during frame 1 busy cycles -> no second frame; o_busy falls after STOP and stays 0.
